// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Purpose  : PC / fetch sequencer with start handshake, branch-target LUT
//            and done detection. Macro: INSTR_FETCH_REL_BRANCH_EN selects
//            PC-relative LUT entries instead of absolute targets.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch #(
  parameter int PC_W      = 10,
  parameter int LUT_IDX_W = 3,
  parameter int END_PC    = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 branch,
  input  logic                 PCSrc,
  input  logic [LUT_IDX_W-1:0] lut_idx,
  input  logic                 hold,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]      lut_wdata,
  output logic [PC_W-1:0]      pc,
  output logic                 running,
  output logic                 done
);

  localparam int              c_LUT_DEPTH = 1 << LUT_IDX_W;
  localparam logic [PC_W-1:0] c_END_PC    = PC_W'(END_PC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_running;
  logic            r_done;
  logic [PC_W-1:0] r_lut [0:c_LUT_DEPTH-1];
  logic [PC_W-1:0] w_target;

`ifdef INSTR_FETCH_REL_BRANCH_EN
  // Entries are signed offsets; modulo add gives the same bits for +/-.
  assign w_target = r_pc + r_lut[lut_idx];
`else
  assign w_target = r_lut[lut_idx];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < c_LUT_DEPTH; i++) begin
        r_lut[i] <= '0;
      end
    end else if (start && lut_we) begin
      r_lut[lut_waddr] <= lut_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pc <= '0;
          if (start) begin
            r_state <= S_ARMED;
          end
        end
        S_ARMED: begin
          r_pc <= '0;
          if (!start) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        S_RUN: begin
          if (start) begin
            r_state   <= S_ARMED;
            r_pc      <= '0;
            r_running <= 1'b0;
          end else if (r_pc == c_END_PC) begin
            // End check precedes hold so a stalled final fetch still finishes.
            r_state   <= S_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end else if (hold) begin
            r_pc <= r_pc;
          end else if (branch && PCSrc) begin
            r_pc <= w_target;
          end else begin
            r_pc <= r_pc + PC_W'(1);
          end
        end
        S_DONE: begin
          if (start) begin
            r_state <= S_ARMED;
            r_pc    <= '0;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_pc      <= '0;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign pc      = r_pc;
  assign running = r_running;
  assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch (END_PC overridden to 20).
`default_nettype none

module tb_instr_fetch;

  localparam int PC_W      = 10;
  localparam int LUT_IDX_W = 3;

`ifdef INSTR_FETCH_REL_BRANCH_EN
  localparam logic [PC_W-1:0] c_LUT2   = 10'h3FD;  // -3
  localparam logic [PC_W-1:0] c_LUT5   = 10'd1020; // 3 + 1020 = 1023
  localparam logic [PC_W-1:0] c_BR5    = 10'd2;
  localparam logic [PC_W-1:0] c_BR9    = 10'd6;
  localparam logic [PC_W-1:0] c_BR2CLR = 10'd2;
`else
  localparam logic [PC_W-1:0] c_LUT2   = 10'd40;
  localparam logic [PC_W-1:0] c_LUT5   = 10'd1023;
  localparam logic [PC_W-1:0] c_BR5    = 10'd40;
  localparam logic [PC_W-1:0] c_BR9    = 10'd40;
  localparam logic [PC_W-1:0] c_BR2CLR = 10'd0;
`endif

  logic                 clk = 1'b0;
  logic                 reset, start, branch, PCSrc, hold, lut_we;
  logic [LUT_IDX_W-1:0] lut_idx, lut_waddr;
  logic [PC_W-1:0]      lut_wdata;
  logic [PC_W-1:0]      pc;
  logic                 running, done;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.PC_W(PC_W), .LUT_IDX_W(LUT_IDX_W), .END_PC(20)) dut (
    .clk(clk), .reset(reset), .start(start), .branch(branch), .PCSrc(PCSrc),
    .lut_idx(lut_idx), .hold(hold), .lut_we(lut_we), .lut_waddr(lut_waddr),
    .lut_wdata(lut_wdata), .pc(pc), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    start = 0; branch = 0; PCSrc = 0; hold = 0;
    lut_we = 0; lut_idx = '0; lut_waddr = '0; lut_wdata = '0;
  endtask

  // Rewind into RUN at pc=0, then advance n sequential steps.
  task automatic run_to(input int n);
    start = 1; step();
    start = 0; step();
    step(n);
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1; step(2);
    checks++; if (pc !== 10'd0) begin errors++; $display("FAIL reset_pc: pc=%0d expected 0", pc); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", running); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    reset = 0; step();
    checks++; if (pc !== 10'd0 || running !== 1'b0) begin errors++; $display("FAIL idle_hold: pc=%0d running=%b expected 0/0", pc, running); end
  endtask

  task automatic test_start();
    start = 1; step(2);
    checks++; if (pc !== 10'd0 || running !== 1'b0) begin errors++; $display("FAIL armed: pc=%0d running=%b expected 0/0", pc, running); end
    start = 0; step();
    checks++; if (pc !== 10'd0 || running !== 1'b1) begin errors++; $display("FAIL run_entry: pc=%0d running=%b expected 0/1", pc, running); end
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++; if (pc !== PC_W'(k)) begin errors++; $display("FAIL seq_step: pc=%0d expected %0d", pc, k); end
    end
  endtask

  task automatic test_branch();
    start = 1; lut_we = 1; lut_waddr = 3'd2; lut_wdata = c_LUT2; step();
    lut_we = 1; lut_waddr = 3'd5; lut_wdata = c_LUT5; step();
    lut_we = 0; start = 0; step();
    step(5);
    checks++; if (pc !== 10'd5) begin errors++; $display("FAIL pre_branch: pc=%0d expected 5", pc); end
    branch = 1; PCSrc = 1; lut_idx = 3'd2; step();
    checks++; if (pc !== c_BR5) begin errors++; $display("FAIL branch_taken: pc=%0d expected %0d", pc, c_BR5); end
    branch = 0; PCSrc = 0;
  endtask

  task automatic test_not_taken();
    lut_idx = 3'd2;
    run_to(7);
    branch = 1; PCSrc = 0; step();
    checks++; if (pc !== 10'd8) begin errors++; $display("FAIL branch_no_pcsrc: pc=%0d expected 8", pc); end
    branch = 0;
    run_to(7);
    PCSrc = 1; step();
    checks++; if (pc !== 10'd8) begin errors++; $display("FAIL pcsrc_no_branch: pc=%0d expected 8", pc); end
    PCSrc = 0;
  endtask

  task automatic test_hold();
    run_to(9);
    hold = 1; branch = 1; PCSrc = 1; lut_idx = 3'd2;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (pc !== 10'd9) begin errors++; $display("FAIL hold_branch: pc=%0d expected 9", pc); end
    end
    hold = 0; step();
    checks++; if (pc !== c_BR9) begin errors++; $display("FAIL hold_release_taken: pc=%0d expected %0d", pc, c_BR9); end
    branch = 0; PCSrc = 0;
    run_to(9);
    hold = 1; branch = 1; PCSrc = 1; step(3);
    hold = 0; branch = 0; PCSrc = 0; step();
    checks++; if (pc !== 10'd10) begin errors++; $display("FAIL hold_release_dropped: pc=%0d expected 10", pc); end
  endtask

  task automatic test_wrap();
    run_to(3);
    branch = 1; PCSrc = 1; lut_idx = 3'd5; step();
    checks++; if (pc !== 10'd1023) begin errors++; $display("FAIL branch_allones: pc=%0d expected 1023", pc); end
    branch = 0; PCSrc = 0; step();
    checks++; if (pc !== 10'd0) begin errors++; $display("FAIL pc_wrap: pc=%0d expected 0", pc); end
  endtask

  task automatic test_done();
    run_to(20);
    checks++; if (pc !== 10'd20 || done !== 1'b0 || running !== 1'b1) begin errors++; $display("FAIL at_end: pc=%0d done=%b running=%b expected 20/0/1", pc, done, running); end
    hold = 1; step();
    checks++; if (pc !== 10'd20 || done !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL done_entry: pc=%0d done=%b running=%b expected 20/1/0", pc, done, running); end
    hold = 0; step(2);
    checks++; if (pc !== 10'd20 || done !== 1'b1) begin errors++; $display("FAIL done_stay: pc=%0d done=%b expected 20/1", pc, done); end
    start = 1; step();
    checks++; if (pc !== 10'd0 || done !== 1'b0) begin errors++; $display("FAIL done_restart: pc=%0d done=%b expected 0/0", pc, done); end
    start = 0; step();
  endtask

  task automatic test_lut_we_ignored();
    run_to(4);
    lut_we = 1; lut_waddr = 3'd2; lut_wdata = 10'd100; step();
    lut_we = 0;
    branch = 1; PCSrc = 1; lut_idx = 3'd2; step();
    checks++; if (pc !== c_BR5) begin errors++; $display("FAIL lut_we_no_start: pc=%0d expected %0d", pc, c_BR5); end
    branch = 0; PCSrc = 0;
  endtask

  task automatic test_reset_mid_run();
    run_to(15);
    reset = 1; step();
    checks++; if (pc !== 10'd0 || running !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_mid_run: pc=%0d running=%b done=%b expected 0/0/0", pc, running, done); end
    reset = 0; step();
    checks++; if (pc !== 10'd0 || running !== 1'b0) begin errors++; $display("FAIL idle_after_reset: pc=%0d running=%b expected 0/0", pc, running); end
    run_to(2);
    branch = 1; PCSrc = 1; lut_idx = 3'd2; step();
    checks++; if (pc !== c_BR2CLR) begin errors++; $display("FAIL lut_cleared: pc=%0d expected %0d", pc, c_BR2CLR); end
    branch = 0; PCSrc = 0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_branch();
    test_not_taken();
    test_hold();
    test_wrap();
    test_done();
    test_lut_we_ignored();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Program-counter and fetch sequencer that consumes the branch decisions produced by the control decoder (`branch`, `PCSrc`) and drives the instruction-memory address. It owns the start/restart handshake, a small branch-target lookup table written while the processor is held in start, and `done` detection at a fixed end address. It sits between the control decoder and instruction ROM in the processor top module.

## Interface
Parameters:
- `PC_W`, 10, program-counter / instruction-address width
- `LUT_IDX_W`, 3, branch-target LUT index width; LUT depth is 2^LUT_IDX_W
- `END_PC`, 1023, address at which the program is considered finished

Ports:
- `clk`  in  1  clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  level; high holds/rewinds the core and enables LUT writes
- `branch`  in  1  branch-class instruction, from control decoder
- `PCSrc`  in  1  take branch target, from control decoder
- `lut_idx`  in  LUT_IDX_W  target-LUT index field of the current instruction
- `hold`  in  1  stall; freezes PC for the cycle
- `lut_we`  in  1  LUT write enable (honoured only while `start`=1)
- `lut_waddr`  in  LUT_IDX_W  LUT write address
- `lut_wdata`  in  PC_W  LUT write data
- `pc`  out  PC_W  current instruction address (registered)
- `running`  out  1  high in RUN
- `done`  out  1  high in DONE

## Operation
- Reset: state IDLE, `pc`=0, `running`=0, `done`=0, all LUT entries 0. Reset overrides every other input, including mid-RUN.
- States: IDLE, ARMED, RUN, DONE.
  - IDLE: `start`=1 -> ARMED. Otherwise stays; `pc` holds 0.
  - ARMED: `pc` forced 0. `start`=0 -> RUN.
  - RUN: `start`=1 -> ARMED (pc=0, restart). Else if `pc`==END_PC -> DONE, `pc` holds. Else PC update below.
  - DONE: `pc` holds END_PC; `start`=1 -> ARMED.
- PC update in RUN (priority order): `hold`=1 -> hold; `branch`&&`PCSrc` -> target; else `pc`+1.
- `PCSrc`=1 with `branch`=0 is ignored (sequential step).
- Target: LUT[`lut_idx`], read combinationally in the same cycle.
- Arithmetic modulo 2^PC_W: `pc`+1 at all-ones wraps to 0 (only reachable if END_PC < all-ones is bypassed by a branch).
- `hold` and a taken branch in the same cycle: hold wins; the branch is not remembered and is re-evaluated from inputs next cycle.
- `END_PC` check precedes `hold`: reaching END_PC enters DONE even if `hold`=1.
- LUT writes: when `start`=1 and `lut_we`=1, LUT[`lut_waddr`] <= `lut_wdata`; ignored in any cycle with `start`=0. Write and read of the same entry in one cycle return the old value.

## Timing
- `pc`, `running`, `done` are registered; all change one cycle after the causing input edge.
- Start handshake: `start` deasserted in cycle N (state ARMED) -> RUN in N+1 with `pc`=0; first advance visible in N+2.
- Branch latency: taken branch sampled at cycle N -> `pc`=target at N+1.
- `done` rises one cycle after `pc`==END_PC is observed in RUN and stays high until `start` or `reset`.
- LUT write at cycle N is readable at N+1.

## Configuration
- `INSTR_FETCH_REL_BRANCH_EN`: defined -> LUT entries are signed PC_W-bit offsets; target = `pc` + LUT[`lut_idx`] modulo 2^PC_W. Undefined -> LUT entries are absolute targets; target = LUT[`lut_idx`]. All other behaviour identical.

## Test plan
- Reset then `start` 1 for 2 cycles, then 0 -> `pc`=0, `running`=1 next cycle, `pc`=1,2,3 on following cycles.
- With `start`=1, write LUT[2]=40; run; at `pc`=5 drive `branch`=1,`PCSrc`=1,`lut_idx`=2 -> `pc`=40 next cycle (absolute build); relative build with LUT[2]=-3 -> `pc`=2.
- `branch`=1,`PCSrc`=0 and `branch`=0,`PCSrc`=1 at `pc`=7 -> `pc`=8 both cases.
- `hold`=1 for 3 cycles together with a taken branch at `pc`=9 -> `pc` stays 9, then after release takes branch only if still presented.
- END_PC=20: run to `pc`=20 -> `done`=1 next cycle, `pc` stays 20; `start`=1 -> `done`=0, `pc`=0.
- `lut_we`=1 with `start`=0 -> LUT unchanged; `reset` asserted mid-RUN at `pc`=15 -> `pc`=0, IDLE, LUT cleared next cycle.
